// File: rtl/seg_scan_ctl.sv
// seg_scan_ctl: time-multiplexed scan controller for common-anode 7-segment
// displays. It rotates through DIGITS active-low digit enables, most
// significant digit first. Each slot starts with a ghosting dead-time, and a
// 16-level brightness gate limits how long the digit is lit. Digit codes are
// latched once per frame, so the display never shows half of one value and
// half of the next.
//
// Optional feature: define SEG_LZ_SUPPRESS_EN to blank leading zeros.
// When it is undefined, no suppression logic is built.

module seg_scan_ctl #(
    parameter int DIGITS        = 4,
    parameter int PRESCALE_BITS = 12,
    parameter int BLANK_CYCLES  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   digits_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  en,
    input  logic [3:0]            bright,
    output logic [DIGITS-1:0]     dis,
    output logic [3:0]            bin_out,
    output logic                  dp_out,
    output logic                  frame_tick
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0]         IDX_LAST  = IDX_W'(DIGITS - 1);
    localparam logic [PRESCALE_BITS-1:0] CNT_MAX   = {PRESCALE_BITS{1'b1}};
    localparam logic [PRESCALE_BITS-1:0] BLANK_LIM = PRESCALE_BITS'(BLANK_CYCLES);

    // Per-slot phase: dead-time first, then the digit may be shown
    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_t;

    // With no dead-time configured, slot count 0 is already in SHOW
    localparam scan_state_t RESET_STATE = (BLANK_CYCLES == 0) ? ST_SHOW : ST_BLANK;

    // Scan counters and phase
    logic [PRESCALE_BITS-1:0] slot_cnt_q, slot_cnt_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    scan_state_t              state_q, state_d;
    logic                     slot_wrap;

    // Frame shadow copies of the display data
    logic [4*DIGITS-1:0]      shadow_dig_q, shadow_dig_d;
    logic [DIGITS-1:0]        shadow_dp_q, shadow_dp_d;
    logic                     frame_start;

    // Registered outputs
    logic [DIGITS-1:0]        dis_q, dis_d;
    logic [3:0]               bin_q, bin_d;
    logic                     dp_q, dp_d;
    logic                     tick_q, tick_d;

    // Selected digit data and lighting qualifiers
    logic [3:0]               cur_dig;
    logic                     cur_dp;
    logic                     bright_ok;
    logic                     suppress;
    logic                     lit;

    // Slot counter free-runs; the digit index steps down on every slot wrap
    always_comb begin
        slot_wrap  = (slot_cnt_q == CNT_MAX);
        slot_cnt_d = slot_cnt_q + 1'b1;
        idx_d      = idx_q;
        if (slot_wrap) begin
            if (idx_q == '0) begin
                idx_d = IDX_LAST;
            end else begin
                idx_d = idx_q - 1'b1;
            end
        end
    end

    // Next phase follows the next counter value, so state_q always matches slot_cnt_q
    always_comb begin
        state_d = ST_SHOW;
        if (slot_cnt_d < BLANK_LIM) begin
            state_d = ST_BLANK;
        end
    end

    // Counter and phase registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt_q <= '0;
            idx_q      <= IDX_LAST;
            state_q    <= RESET_STATE;
        end else begin
            slot_cnt_q <= slot_cnt_d;
            idx_q      <= idx_d;
            state_q    <= state_d;
        end
    end

    // Capture the inputs only at frame start so that a frame is never torn
    always_comb begin
        frame_start  = (slot_cnt_q == '0) && (idx_q == IDX_LAST);
        shadow_dig_d = shadow_dig_q;
        shadow_dp_d  = shadow_dp_q;
        if (frame_start) begin
            shadow_dig_d = digits_in;
            shadow_dp_d  = dp_in;
        end
    end

    // Shadow registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_dig_q <= '0;
            shadow_dp_q  <= '0;
        end else begin
            shadow_dig_q <= shadow_dig_d;
            shadow_dp_q  <= shadow_dp_d;
        end
    end

    // Use the value being latched on the load cycle so the first slot sees the new frame
    always_comb begin
        cur_dig   = shadow_dig_d[{idx_q, 2'b00} +: 4];
        cur_dp    = shadow_dp_d[idx_q];
        bright_ok = (slot_cnt_q[PRESCALE_BITS-1 -: 4] <= bright);
    end

`ifdef SEG_LZ_SUPPRESS_EN
    logic [DIGITS-1:0] lz_mask;

    // Walk down from the MSD; a digit stays blank while it and every digit above it are zero with no dp
    always_comb begin
        logic lz_run;
        lz_run  = 1'b1;
        lz_mask = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            lz_run = lz_run & (shadow_dig_d[4*k +: 4] == 4'd0) & ~shadow_dp_d[k];
            if (k > 0) begin
                lz_mask[k] = lz_run;
            end
        end
    end

    assign suppress = lz_mask[idx_q];
`else
    assign suppress = 1'b0;
`endif

    // Output decode: light the current digit only in SHOW, inside the brightness window and when enabled
    always_comb begin
        lit    = en && (state_q == ST_SHOW) && bright_ok && !suppress;
        dis_d  = '1;
        dp_d   = 1'b1;
        bin_d  = en ? cur_dig : 4'd0;
        tick_d = slot_wrap && (idx_q == '0);
        if (lit) begin
            dis_d[idx_q] = 1'b0;
            dp_d         = ~cur_dp;
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dis_q  <= '1;
            bin_q  <= 4'd0;
            dp_q   <= 1'b1;
            tick_q <= 1'b0;
        end else begin
            dis_q  <= dis_d;
            bin_q  <= bin_d;
            dp_q   <= dp_d;
            tick_q <= tick_d;
        end
    end

    assign dis        = dis_q;
    assign bin_out    = bin_q;
    assign dp_out     = dp_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_ctl.sv
// tb_seg_scan_ctl: directed bench for seg_scan_ctl with DIGITS=4,
// PRESCALE_BITS=6 and BLANK_CYCLES=4. Edge number E counts rising edges
// after reset release. The output seen after edge E reflects the counter
// step s=E-1, where slot=s/64, cnt=s%64 and idx=3-(slot%4).

module tb_seg_scan_ctl;

    localparam int DIGITS = 4;
    localparam int PB     = 6;
    localparam int BC     = 4;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [4*DIGITS-1:0] digits_in;
    logic [DIGITS-1:0]  dp_in;
    logic               en;
    logic [3:0]         bright;
    logic [DIGITS-1:0]  dis;
    logic [3:0]         bin_out;
    logic               dp_out;
    logic               frame_tick;

    int errors = 0;
    int checks = 0;
    int edge_n = 0;

    seg_scan_ctl #(
        .DIGITS(DIGITS),
        .PRESCALE_BITS(PB),
        .BLANK_CYCLES(BC)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .digits_in(digits_in),
        .dp_in(dp_in),
        .en(en),
        .bright(bright),
        .dis(dis),
        .bin_out(bin_out),
        .dp_out(dp_out),
        .frame_tick(frame_tick)
    );

    // Free-running 100 MHz clock
    always #5 clk = ~clk;

    // Advance one rising edge and sample just after it
    task automatic tick();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    // Advance to a given edge number after reset release
    task automatic advanceTo(input int target);
        while (edge_n < target) tick();
    endtask

    // Drive all data inputs at once
    task automatic applyStimulus(input logic [15:0] dig, input logic [3:0] dp,
                                 input logic e, input logic [3:0] b);
        digits_in = dig;
        dp_in     = dp;
        en        = e;
        bright    = b;
    endtask

    // Compare the digit outputs against hand-computed values
    task automatic checkOutput(input string tag, input logic [3:0] exp_dis,
                               input logic [3:0] exp_bin, input logic exp_dp);
        checks++;
        assert (dis === exp_dis) else begin
            errors++;
            $error("[TB] FAIL %s dis: observed %b expected %b", tag, dis, exp_dis);
        end
        checks++;
        assert (bin_out === exp_bin) else begin
            errors++;
            $error("[TB] FAIL %s bin_out: observed %h expected %h", tag, bin_out, exp_bin);
        end
        checks++;
        assert (dp_out === exp_dp) else begin
            errors++;
            $error("[TB] FAIL %s dp_out: observed %b expected %b", tag, dp_out, exp_dp);
        end
    endtask

    // Compare the frame tick
    task automatic checkTick(input string tag, input logic exp_tick);
        checks++;
        assert (frame_tick === exp_tick) else begin
            errors++;
            $error("[TB] FAIL %s frame_tick: observed %b expected %b", tag, frame_tick, exp_tick);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(16'h1234, 4'b0000, 1'b1, 4'd15);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset", 4'b1111, 4'h0, 1'b1);
        checkTick("reset", 1'b0);

        @(negedge clk);
        rst_n  = 1'b1;
        edge_n = 0;
        $display("[TB] basic scan");

        // Basic scan of 0x1234
        advanceTo(1);   checkOutput("scan_blank_first", 4'b1111, 4'h1, 1'b1);
        advanceTo(4);   checkOutput("scan_blank_last",  4'b1111, 4'h1, 1'b1);
        advanceTo(5);   checkOutput("scan_d3_on",       4'b0111, 4'h1, 1'b1);
        advanceTo(64);  checkOutput("scan_d3_end",      4'b0111, 4'h1, 1'b1);
        advanceTo(65);  checkOutput("scan_d2_blank",    4'b1111, 4'h2, 1'b1);
        advanceTo(69);  checkOutput("scan_d2_on",       4'b1011, 4'h2, 1'b1);
        advanceTo(133); checkOutput("scan_d1_on",       4'b1101, 4'h3, 1'b1);
        advanceTo(197); checkOutput("scan_d0_on",       4'b1110, 4'h4, 1'b1);
        advanceTo(255); checkTick("tick_before", 1'b0);
        advanceTo(256); checkTick("tick_pulse", 1'b1);
        advanceTo(257); checkTick("tick_after", 1'b0);

        // Shadow latch: change the inputs mid-frame
        $display("[TB] shadow latch");
        advanceTo(390);
        applyStimulus(16'h5678, 4'b0000, 1'b1, 4'd15);
        advanceTo(400); checkOutput("latch_old_d1", 4'b1101, 4'h3, 1'b1);
        advanceTo(461); checkOutput("latch_old_d0", 4'b1110, 4'h4, 1'b1);
        advanceTo(512); checkTick("tick_frame2", 1'b1);
        advanceTo(513); checkOutput("latch_new_blank", 4'b1111, 4'h5, 1'b1);
        advanceTo(517); checkOutput("latch_new_d3", 4'b0111, 4'h5, 1'b1);
        advanceTo(581); checkOutput("latch_new_d2", 4'b1011, 4'h6, 1'b1);
        advanceTo(645); checkOutput("latch_new_d1", 4'b1101, 4'h7, 1'b1);
        advanceTo(709); checkOutput("latch_new_d0", 4'b1110, 4'h8, 1'b1);

        // Brightness 3: lit only for cnt 4..15
        $display("[TB] brightness");
        advanceTo(768);
        applyStimulus(16'h5678, 4'b0000, 1'b1, 4'd3);
        advanceTo(772); checkOutput("bright3_blank", 4'b1111, 4'h5, 1'b1);
        advanceTo(773); checkOutput("bright3_first", 4'b0111, 4'h5, 1'b1);
        advanceTo(784); checkOutput("bright3_last",  4'b0111, 4'h5, 1'b1);
        advanceTo(785); checkOutput("bright3_off",   4'b1111, 4'h5, 1'b1);

        // Brightness 0: never lit with four blank cycles
        advanceTo(832);
        applyStimulus(16'h5678, 4'b0000, 1'b1, 4'd0);
        advanceTo(837); checkOutput("bright0_early", 4'b1111, 4'h6, 1'b1);
        advanceTo(880); checkOutput("bright0_late",  4'b1111, 4'h6, 1'b1);

        // Decimal point on digit 2, visible from the next frame
        $display("[TB] decimal point and enable");
        advanceTo(896);
        applyStimulus(16'h5678, 4'b0000, 1'b1, 4'd15);
        advanceTo(900);
        applyStimulus(16'h5678, 4'b0100, 1'b1, 4'd15);
        advanceTo(1000); checkOutput("dp_not_yet",   4'b1110, 4'h8, 1'b1);
        advanceTo(1030); checkOutput("dp_d3_off",    4'b0111, 4'h5, 1'b1);
        advanceTo(1089); checkOutput("dp_d2_blank",  4'b1111, 4'h6, 1'b1);
        advanceTo(1093); checkOutput("dp_d2_on",     4'b1011, 4'h6, 1'b0);
        advanceTo(1152); checkOutput("dp_d2_end",    4'b1011, 4'h6, 1'b0);
        advanceTo(1153); checkOutput("dp_d1_off",    4'b1111, 4'h7, 1'b1);

        // Enable off, then back on at the right phase
        advanceTo(1290);
        applyStimulus(16'h5678, 4'b0100, 1'b0, 4'd15);
        advanceTo(1291); checkOutput("en_off_d3", 4'b1111, 4'h0, 1'b1);
        advanceTo(1360); checkOutput("en_off_d2", 4'b1111, 4'h0, 1'b1);
        advanceTo(1400);
        applyStimulus(16'h5678, 4'b0100, 1'b1, 4'd15);
        advanceTo(1401); checkOutput("en_on_d2",    4'b1011, 4'h6, 1'b0);
        advanceTo(1409); checkOutput("en_on_blank", 4'b1111, 4'h7, 1'b1);
        advanceTo(1413); checkOutput("en_on_d1",    4'b1101, 4'h7, 1'b1);

        // Leading zeros: 0x0042
        $display("[TB] leading zeros");
        advanceTo(1420);
        applyStimulus(16'h0042, 4'b0000, 1'b1, 4'd15);
`ifdef SEG_LZ_SUPPRESS_EN
        advanceTo(1541); checkOutput("lz42_d3", 4'b1111, 4'h0, 1'b1);
        advanceTo(1605); checkOutput("lz42_d2", 4'b1111, 4'h0, 1'b1);
`else
        advanceTo(1541); checkOutput("lz42_d3", 4'b0111, 4'h0, 1'b1);
        advanceTo(1605); checkOutput("lz42_d2", 4'b1011, 4'h0, 1'b1);
`endif
        advanceTo(1669); checkOutput("lz42_d1", 4'b1101, 4'h4, 1'b1);
        advanceTo(1733); checkOutput("lz42_d0", 4'b1110, 4'h2, 1'b1);

        // Leading zeros: 0x0000
        advanceTo(1700);
        applyStimulus(16'h0000, 4'b0000, 1'b1, 4'd15);
        advanceTo(1792); checkTick("tick_frame7", 1'b1);
`ifdef SEG_LZ_SUPPRESS_EN
        advanceTo(1797); checkOutput("lz0_d3", 4'b1111, 4'h0, 1'b1);
        advanceTo(1861); checkOutput("lz0_d2", 4'b1111, 4'h0, 1'b1);
        advanceTo(1925); checkOutput("lz0_d1", 4'b1111, 4'h0, 1'b1);
`else
        advanceTo(1797); checkOutput("lz0_d3", 4'b0111, 4'h0, 1'b1);
        advanceTo(1861); checkOutput("lz0_d2", 4'b1011, 4'h0, 1'b1);
        advanceTo(1925); checkOutput("lz0_d1", 4'b1101, 4'h0, 1'b1);
`endif
        advanceTo(1989); checkOutput("lz0_d0", 4'b1110, 4'h0, 1'b1);
        advanceTo(2000); checkOutput("pre_reset", 4'b1110, 4'h0, 1'b1);

        // Asynchronous reset mid-slot, then restart at the MSD
        $display("[TB] reset mid-scan");
        applyStimulus(16'h1234, 4'b0000, 1'b1, 4'd15);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", 4'b1111, 4'h0, 1'b1);
        checkTick("async_reset", 1'b0);
        @(posedge clk);
        #1;
        checkOutput("reset_held", 4'b1111, 4'h0, 1'b1);
        @(negedge clk);
        rst_n  = 1'b1;
        edge_n = 0;
        advanceTo(1); checkOutput("restart_blank", 4'b1111, 4'h1, 1'b1);
        advanceTo(4); checkOutput("restart_blank4", 4'b1111, 4'h1, 1'b1);
        advanceTo(5); checkOutput("restart_d3", 4'b0111, 4'h1, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
